// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction memory and feeds decode from a 2-entry FIFO.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t      fifo_q [2];
   logic [31:0] pc_q, pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        inflight_q, inflight_d;
   logic        kill_q, kill_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;

   logic        pop, push, issue;
   logic [1:0]  occ;

   // Outstanding work: buffered words plus the word still in the memory pipe.
   assign occ      = count_q + {1'b0, inflight_q};
   assign if_valid = ~rst & (count_q != 2'd0);
   assign pop      = if_valid & id_ready & ~redirect_valid;
   assign issue    = ~rst & ~redirect_valid & ((occ < 2'd2) | ((occ == 2'd2) & pop));
   assign push     = inflight_q & ~kill_q & ~redirect_valid;

   assign imem_req  = issue;
   assign imem_addr = pc_q;
   assign if_instr  = if_valid ? fifo_q[rd_ptr_q].instr : NOP_INSTR;
   assign if_pc     = if_valid ? fifo_q[rd_ptr_q].pc    : 32'h0;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
      kill_d        = 1'b0;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if (redirect_valid) begin
         // A redirect discards the FIFO and whatever the memory returns next.
         pc_d     = {redirect_pc[31:2], 2'b00};
         kill_d   = inflight_q;
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (issue) pc_d = pc_q + 32'd4;
         if (push)  wr_ptr_d = ~wr_ptr_q;
         if (pop)   rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_pc_q <= 32'h0;
         inflight_q    <= 1'b0;
         kill_q        <= 1'b0;
         count_q       <= 2'd0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
         kill_q        <= kill_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   // NOTE: FIFO storage is not reset; count_q alone decides which entries are
   // meaningful, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push & ~rst) fifo_q[wr_ptr_q] <= {imem_rdata, inflight_pc_q};
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && !pop && count_q == 2'd2));
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the expected instruction stream is derived
// from reset/redirect targets and compared on every decode handshake.
module tb_fetch_stage;

   localparam logic [31:0] MAIN_RESET_PC = 32'h0000_1000;
   localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP           = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready = 1'b0;

   logic        rst_w = 1'b1;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc;
   logic [31:0] w_rdata = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   fetch_stage #(.RESET_PC(MAIN_RESET_PC), .NOP_INSTR(NOP)) u_dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready)
   );

   fetch_stage #(.RESET_PC(WRAP_RESET_PC), .NOP_INSTR(NOP)) u_wrap (
      .clk(clk), .rst(rst_w),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc),
      .id_ready(1'b1)
   );

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) begin
      imem_rdata <= imem_req ? word_at(imem_addr) : 32'hBAD0_BAD0;
      w_rdata    <= w_req    ? word_at(w_addr)    : 32'hBAD0_BAD0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected stream: each stimulus cycle extends it by one address; a reset
   // or redirect restarts it at the new target.
   logic [31:0] exp_q[$];
   logic [31:0] nxt_pc = 32'h0;
   logic        chk_noreq = 1'b0;

   task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic noreq);
      logic [31:0] t;
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      id_ready       = rdy;
      chk_noreq      = noreq;
      if (r) begin
         exp_q.delete();
         exp_q.push_back(MAIN_RESET_PC);
         nxt_pc = MAIN_RESET_PC + 32'd4;
      end else if (rv) begin
         t = {rpc[31:2], 2'b00};
         exp_q.delete();
         exp_q.push_back(t);
         nxt_pc = t + 32'd4;
      end else begin
         exp_q.push_back(nxt_pc);
         nxt_pc = nxt_pc + 32'd4;
      end
   endtask

   // Cycles since the last reset/redirect cycle, and the target it set.
   int          age = 0;
   logic [31:0] tgt = 32'h0;
   always @(posedge clk) begin
      if (rst) begin
         age <= 1;
         tgt <= MAIN_RESET_PC;
      end else if (redirect_valid) begin
         age <= 1;
         tgt <= {redirect_pc[31:2], 2'b00};
      end else if (age != 0 && age < 1000) begin
         age <= age + 1;
      end
   end

   logic [31:0] e;
   always @(negedge clk) begin
      if (rst) begin
         check("reset_valid", 64'(if_valid), 64'(0));
         check("reset_req", 64'(imem_req), 64'(0));
         check("reset_out", {if_instr, if_pc}, {NOP, 32'h0});
      end else if (age != 0) begin
         if (redirect_valid)
            check("redirect_no_req", 64'(imem_req), 64'(0));
         else if (age == 1)
            check("first_req", {31'b0, imem_req, imem_addr}, {31'b0, 1'b1, tgt});
         if (chk_noreq)
            check("stall_no_req", 64'(imem_req), 64'(0));
         check("valid_timing", 64'(if_valid), 64'(age >= 3));
         if (!if_valid) begin
            check("empty_out", {if_instr, if_pc}, {NOP, 32'h0});
         end else if (id_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL pop_unexpected: got pc %h with no expected entry", if_pc);
            end else begin
               e = exp_q.pop_front();
               check("pop_word", {if_pc, if_instr}, {e, word_at(e)});
            end
         end
      end
   end

   // Wrap instance: PC sequence must roll over from 0xFFFF_FFFC to 0.
   logic wrap_done = 1'b0;
   initial begin
      logic [31:0] wexp [3];
      int got;
      wexp[0] = 32'hFFFF_FFF8;
      wexp[1] = 32'hFFFF_FFFC;
      wexp[2] = 32'h0000_0000;
      got = 0;
      repeat (3) @(posedge clk);
      #1 rst_w = 1'b0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         if (w_valid) begin
            check("wrap_pc", {w_pc, w_instr}, {wexp[got], word_at(wexp[got])});
            got++;
         end
      end
      if (got < 3) begin
         vectors++;
         miscompares++;
         $display("FAIL wrap_timeout: got %0d words expected 3", got);
      end
      wrap_done = 1'b1;
   end

   initial begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      repeat (3)  step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // Five-cycle stall: fetch must stop once the buffer plus pipe is full.
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (4)  step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      repeat (6)  step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      repeat (3)  step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      repeat (8)  step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0);
      repeat (6)  step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
      repeat (6)  step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      repeat (8)  step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         r   = ($urandom_range(0, 199) == 0);
         rv  = !r && ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom());
         rdy = ($urandom_range(0, 9) < 7);
         step(r, rv, rpc, rdy, 1'b0);
      end
      repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int c = 0; c < 50 && !wrap_done; c++) @(posedge clk);
      if (!wrap_done) begin
         vectors++;
         miscompares++;
         $display("FAIL wrap_done: got 0 expected 1");
      end
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
